// File: rtl/pipe_pkg.sv
// Shared pipeline types: decoded control word, the zero register number and the NOP control value.
package pipe_pkg;

   typedef struct packed {
      logic       regwrite;
      logic       memread;
      logic       memwrite;
      logic       memtoreg;
      logic       alusrc;
      logic       branch;
      logic [1:0] aluop;
   } ctrl_t;

   localparam logic [4:0] XZR      = 5'd31;
   localparam ctrl_t      CTRL_NOP = '0;

   // A source only depends on a producer when it names the same, non-zero register.
   function automatic logic src_hit(input logic [4:0] wa, input logic [4:0] ra);
      return (wa == ra) && (ra != XZR);
   endfunction

endpackage

// File: rtl/hazard_id_ex_hazard_detect.sv
// Load-use hazard detection between the instruction in EX and the one in ID.
module hazard_detect
   import pipe_pkg::*;
(
   input  logic       ex_valid,
   input  logic       ex_memread,
   input  logic [4:0] ex_wa,
   input  logic       id_valid,
   input  logic [4:0] id_ra1,
   input  logic [4:0] id_ra2,
   input  logic       flush,
   output logic       stall
);

   logic ex_load;
   logic dep;

   assign ex_load = ex_valid && ex_memread && (ex_wa != XZR);
   assign dep     = src_hit(ex_wa, id_ra1) || src_hit(ex_wa, id_ra2);
   // A flushed ID instruction is dead, so it must not hold the front end.
   assign stall   = ex_load && id_valid && dep && !flush;

endmodule

// File: rtl/hazard_id_ex.sv
// ID/EX pipeline register with load-use bubble insertion and flush.
// Optional build macro HAZARD_PERF_CNT_EN adds saturating stall/flush counters.
module hazard_id_ex
   import pipe_pkg::*;
(
   input  logic        clk,
   input  logic        reset_n,
   input  logic        id_valid,
   input  logic [4:0]  id_ra1,
   input  logic [4:0]  id_ra2,
   input  logic [4:0]  id_wa,
   input  logic [63:0] id_rd1,
   input  logic [63:0] id_rd2,
   input  logic [63:0] id_imm,
   input  ctrl_t       id_ctrl,
   input  logic        flush,
   output logic        ex_valid,
   output logic [4:0]  ex_ra1,
   output logic [4:0]  ex_ra2,
   output logic [4:0]  ex_wa,
   output logic [63:0] ex_rd1,
   output logic [63:0] ex_rd2,
   output logic [63:0] ex_imm,
   output ctrl_t       ex_ctrl,
   output logic        stall,
   output logic [31:0] stall_count,
   output logic [31:0] flush_count
);

   logic bubble;

   hazard_detect u_detect (
      .ex_valid   (ex_valid),
      .ex_memread (ex_ctrl.memread),
      .ex_wa      (ex_wa),
      .id_valid   (id_valid),
      .id_ra1     (id_ra1),
      .id_ra2     (id_ra2),
      .flush      (flush),
      .stall      (stall)
   );

   assign bubble = flush || stall || !id_valid;

   // Bubbles clear every field so a dead slot can never write registers or memory.
   always_ff @(posedge clk) begin
      if (!reset_n || bubble) begin
         ex_valid <= 1'b0;
         ex_ra1   <= '0;
         ex_ra2   <= '0;
         ex_wa    <= '0;
         ex_rd1   <= '0;
         ex_rd2   <= '0;
         ex_imm   <= '0;
         ex_ctrl  <= CTRL_NOP;
      end else begin
         ex_valid <= 1'b1;
         ex_ra1   <= id_ra1;
         ex_ra2   <= id_ra2;
         ex_wa    <= id_wa;
         ex_rd1   <= id_rd1;
         ex_rd2   <= id_rd2;
         ex_imm   <= id_imm;
         ex_ctrl  <= id_ctrl;
      end
   end

`ifdef HAZARD_PERF_CNT_EN
   logic [31:0] stall_cnt;
   logic [31:0] flush_cnt;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         stall_cnt <= '0;
         flush_cnt <= '0;
      end else begin
         if (stall && (stall_cnt != 32'hFFFF_FFFF)) stall_cnt <= stall_cnt + 32'd1;
         if (flush && (flush_cnt != 32'hFFFF_FFFF)) flush_cnt <= flush_cnt + 32'd1;
      end
   end

   assign stall_count = stall_cnt;
   assign flush_count = flush_cnt;
`else
   assign stall_count = '0;
   assign flush_count = '0;
`endif

endmodule

// File: doc/hazard_id_ex.md
HAZARD_ID_EX -- requirements
Module: hazard_id_ex

Interface
REQ-001 The block SHALL have one clock and no parameters; reset is synchronous and active-low.
REQ-002 clk  in  1  rising-edge clock for all state.
REQ-003 reset_n  in  1  synchronous reset, active-low.
REQ-004 id_valid  in  1  decode stage holds a real instruction.
REQ-005 id_ra1, id_ra2  in  5 each  source register numbers sent to the register file.
REQ-006 id_wa  in  5  destination register number.
REQ-007 id_rd1, id_rd2  in  64 each  register file read data, already write-forwarded.
REQ-008 id_imm  in  64  sign-extended immediate.
REQ-009 id_ctrl  in  ctrl_t (8)  fields: regwrite, memread, memwrite, memtoreg, alusrc, branch, aluop[1:0].
REQ-010 flush  in  1  taken branch resolved downstream; kill the ID instruction.
REQ-011 ex_valid  out  1  EX stage holds a real instruction.
REQ-012 ex_ra1, ex_ra2, ex_wa  out  5 each  registered register numbers.
REQ-013 ex_rd1, ex_rd2, ex_imm  out  64 each  registered operands.
REQ-014 ex_ctrl  out  ctrl_t  registered control.
REQ-015 stall  out  1  combinational; hold PC and IF/ID this cycle.
REQ-016 stall_count, flush_count  out  32 each  performance counters.

Function
REQ-017 Latency SHALL be 1 cycle: when not stalling or flushing, all id_* fields appear on ex_* after the next rising edge.
REQ-018 Hazard: stall SHALL be 1 iff ex_valid & ex_ctrl.memread & ex_wa!=31 & id_valid & ((ex_wa==id_ra1 & id_ra1!=31) | (ex_wa==id_ra2 & id_ra2!=31)) & !flush.
REQ-019 Register 31 (XZR) SHALL never cause a hazard.
REQ-020 On an edge with stall=1, the stage SHALL load a bubble: ex_valid=0, ex_ctrl=0, all data/number fields=0. Upstream holds id_* stable.
REQ-021 The cycle after a bubble, ex_valid=0, so stall SHALL drop and the held instruction SHALL load normally. Load-use costs exactly 1 bubble.
REQ-022 On an edge with flush=1, the stage SHALL load a bubble regardless of stall or id_valid. Flush has priority over stall.
REQ-023 On an edge with id_valid=0, the stage SHALL load a bubble.
REQ-024 ex_ctrl SHALL be all-zero whenever ex_valid=0, so bubbles never write registers or memory.
REQ-025 There SHALL be no multi-cycle state beyond the bubble. Back-to-back loads with independent consumers SHALL not stall.

Reset
REQ-026 While reset_n=0 at an edge, all ex_* outputs and both counters SHALL clear to 0.
REQ-027 stall SHALL be 0 in the cycle after reset. A reset asserted mid-stall SHALL discard the held hazard.

Configuration
REQ-028 With macro HAZARD_PERF_CNT_EN defined: stall_count SHALL increment on each edge with stall=1, and flush_count on each edge with flush=1; both saturate at 32'hFFFFFFFF.
REQ-029 Without HAZARD_PERF_CNT_EN: no counter flops are built, and both count ports SHALL be tied to 0.

Structure
REQ-030 Package pipe_pkg SHALL hold ctrl_t (packed struct), the constant XZR=5'd31, and the constant CTRL_NOP='0. It is shared with the control unit and later stages.
REQ-031 One sub-module, hazard_detect, SHALL hold the combinational REQ-018 logic. The pipeline register stays in hazard_id_ex.

Verification
REQ-032 Load X2 into EX (ex_wa=2, memread=1), with ID ra1=2 -> stall=1; next edge ex_valid=0; following edge ex_rd1 equals id_rd1.
REQ-033 Same as REQ-032 but ra1=31, ex_wa=31 -> stall=0; no bubble.
REQ-034 ex_wa=5 with memread=0, ID ra2=5 -> stall=0.
REQ-035 Load-use hazard and flush=1 in the same cycle -> stall=0; next ex_valid=0 and ex_ctrl=0; flush_count +1 (with macro).
REQ-036 Drive id_rd1=64'hDEAD, id_imm=64'h10, valid, no hazard -> next cycle ex_rd1=64'hDEAD, ex_imm=64'h10, ex_valid=1.
REQ-037 reset_n=0 during a stall cycle -> next cycle all ex_*=0, stall=0, counters=0.
